pc104_pid_gain_regs: RTL and testbench
======================================

# pc104_pid_gain_regs

PC/104 I/O-space register file that captures host writes of the PID proportional and integral gains and drives them out as IO_A/IO_B, the gain buses consumed by the signal-board CPLD. Host strobes are asynchronous to the 1 MHz CPLD clock. They are synchronised and edge-detected before any register update. Gains are double-buffered (shadow, then active) so P and I change together on an explicit commit. A read-back path returns shadow, active-gain status and version on IN_SD.

## Interface
Parameters:
- BASE_ADDR, 10'h300: I/O base address; the block decodes SA[9:2] == BASE_ADDR[9:2].
- VERSION, 4'h1: constant returned in the status register.
- P_RESET, 8'h00: reset value of the P shadow and IO_A.
- I_RESET, 8'h00: reset value of the I shadow and IO_B.

Ports:
- clk  in  1  1 MHz system clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- SA  in  10  PC/104 address, asynchronous.
- AEN  in  1  PC/104 DMA address enable; 1 = cycle ignored.
- IOW_N  in  1  PC/104 I/O write strobe, active low, asynchronous.
- IOR_N  in  1  PC/104 I/O read strobe, active low, asynchronous.
- OUT_SD  in  [15:8]  host write data byte.
- IN_SD  out  [15:8]  read-back data byte.
- IN_SD_OE  out  1  read-back drive enable, active high.
- IO_A  out  8  active P gain.
- IO_B  out  8  active I gain.
- GAIN_UPD  out  1  one-clk pulse when IO_A/IO_B are loaded.

## Operation
Register map (offset = SA[1:0]):
- 0: P shadow, read/write.
- 1: I shadow, read/write.
- 2: control, write-only; reads return 8'h00.
  - bit0 COMMIT: copy both shadows into IO_A/IO_B and pulse GAIN_UPD.
  - bit7 CLEAR: load IO_A = IO_B = 8'h00 and pulse GAIN_UPD; shadows are unchanged.
  - Other bits are ignored.
- 3: status, read-only: {VERSION[3:0], commit_cnt[3:0]}. Writes are ignored.

commit_cnt:
- 4-bit counter, incremented on every GAIN_UPD.
- Wraps from 4'hF to 4'h0.

Write path:
- IOW_N passes through a 2-FF synchronizer (s1, s2) followed by a history flop s3.
- wr_fall = ~s2 & s3.
- On the clk edge where wr_fall = 1, if AEN = 0 and the address hits, SA[1:0] and OUT_SD are sampled from the live bus and the addressed register is updated.
- A write to offset 2 with both bit0 and bit7 set: CLEAR wins, IO_A = IO_B = 0, and exactly one GAIN_UPD pulse is issued.
- Exactly one write is performed per strobe. A new write requires IOW_N to be seen high again (s2 = 1).

Read path (combinational, no state change):
- IN_SD_OE = ~IOR_N & ~AEN & address hit.
- IN_SD = registered contents at offset SA[1:0]. It is driven whenever IN_SD_OE = 1 and is 8'h00 otherwise.
- Reading never changes state.

Reset, applied on the clk edge with rst = 1:
- P shadow and IO_A = P_RESET.
- I shadow and IO_B = I_RESET.
- commit_cnt = 0, GAIN_UPD = 0.
- s1, s2, s3 = 1 (idle), so a strobe already low at reset release is seen as a new falling edge after the sync delay.
- Reset dominates any write detected in the same cycle.

## Timing
- Bus requirement: IOW_N low for at least 4 clk periods (4 µs, host inserts wait states). SA, AEN and OUT_SD stable for the whole strobe-low time.
- Write latency: if edge k is the first clk edge at which IOW_N is sampled low, the register update occurs at edge k+2.
- GAIN_UPD is high for the single cycle following edge k+2. IO_A/IO_B take their new values at that same edge.
- Read: purely combinational from SA/IOR_N/AEN; no clock latency.
- Strobe glitches shorter than 1 clk may be missed. Glitches that are caught produce at most one write.

## Test plan
- Reset: hold rst for 2 clk with P_RESET = 8'h12, I_RESET = 8'h34 -> IO_A = 8'h12, IO_B = 8'h34, GAIN_UPD = 0, status read = 8'h10.
- Shadow vs active: write 0x300 = 8'hA5 and 0x301 = 8'h3C -> IO_A/IO_B unchanged, reading 0x300 returns 8'hA5. Then write 0x302 = 8'h01 -> at edge k+2, IO_A = 8'hA5, IO_B = 8'h3C, one GAIN_UPD pulse, status = 8'h11.
- CLEAR priority: write 0x302 = 8'h81 -> IO_A = IO_B = 0, shadows still 8'hA5/8'h3C, exactly one GAIN_UPD pulse.
- Qualification: write with AEN = 1, write to SA = 0x310, and an IOW_N strobe held low for 10 clk -> first two: no change and no GAIN_UPD; long strobe: exactly one write.
- Counter wrap: 16 commits from reset -> status [3:0] returns to 4'h0. Read of offset 2 returns 8'h00, and IN_SD_OE = 0 whenever IOR_N = 1.
- Reset mid-write: assert rst at edge k+1 of a COMMIT write -> all registers at reset values, no GAIN_UPD. IOW_N still low after rst release -> one write performed 2 clk later.

Source files
------------

// File: rtl/pc104_pid_gain_regs.sv
// PC/104 I/O register file holding double-buffered PID P/I gains for the signal-board CPLD.
// Host write strobe is synchronised to clk and edge-detected; reads are purely combinational.
module pc104_pid_gain_regs #(
  parameter logic [9:0] BASE_ADDR = 10'h300,
  parameter logic [3:0] VERSION   = 4'h1,
  parameter logic [7:0] P_RESET   = 8'h00,
  parameter logic [7:0] I_RESET   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  SA,
  input  logic        AEN,
  input  logic        IOW_N,
  input  logic        IOR_N,
  input  logic [15:8] OUT_SD,
  output logic [15:8] IN_SD,
  output logic        IN_SD_OE,
  output logic [7:0]  IO_A,
  output logic [7:0]  IO_B,
  output logic        GAIN_UPD
);

  logic       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [7:0] p_shadow_q, p_shadow_d;
  logic [7:0] i_shadow_q, i_shadow_d;
  logic [7:0] io_a_q, io_a_d;
  logic [7:0] io_b_q, io_b_d;
  logic       gain_upd_q, gain_upd_d;
  logic [3:0] commit_cnt_q, commit_cnt_d;

  logic       addr_hit;
  logic       wr_fall;
  logic       wr_en;
  logic [7:0] rd_data;

  assign addr_hit = (SA[9:2] == BASE_ADDR[9:2]);
  // s3 lags s2 by one clock, so a low strobe yields a single-cycle write enable.
  assign wr_fall  = ~s2_q & s3_q;
  assign wr_en    = wr_fall & ~AEN & addr_hit;

  always_comb begin
    s1_d         = IOW_N;
    s2_d         = s1_q;
    s3_d         = s2_q;
    p_shadow_d   = p_shadow_q;
    i_shadow_d   = i_shadow_q;
    io_a_d       = io_a_q;
    io_b_d       = io_b_q;
    gain_upd_d   = 1'b0;
    commit_cnt_d = commit_cnt_q;
    if (wr_en) begin
      case (SA[1:0])
        2'd0: p_shadow_d = OUT_SD;
        2'd1: i_shadow_d = OUT_SD;
        2'd2: begin
          // CLEAR outranks COMMIT when both bits are set.
          if (OUT_SD[15]) begin
            io_a_d     = 8'h00;
            io_b_d     = 8'h00;
            gain_upd_d = 1'b1;
          end else if (OUT_SD[8]) begin
            io_a_d     = p_shadow_q;
            io_b_d     = i_shadow_q;
            gain_upd_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (gain_upd_d) begin
      commit_cnt_d = commit_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      s3_q         <= 1'b1;
      p_shadow_q   <= P_RESET;
      i_shadow_q   <= I_RESET;
      io_a_q       <= P_RESET;
      io_b_q       <= I_RESET;
      gain_upd_q   <= 1'b0;
      commit_cnt_q <= 4'd0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      p_shadow_q   <= p_shadow_d;
      i_shadow_q   <= i_shadow_d;
      io_a_q       <= io_a_d;
      io_b_q       <= io_b_d;
      gain_upd_q   <= gain_upd_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (SA[1:0])
      2'd0:    rd_data = p_shadow_q;
      2'd1:    rd_data = i_shadow_q;
      2'd3:    rd_data = {VERSION, commit_cnt_q};
      default: rd_data = 8'h00;
    endcase
  end

  assign IN_SD_OE = ~IOR_N & ~AEN & addr_hit;
  assign IN_SD    = IN_SD_OE ? rd_data : 8'h00;
  assign IO_A     = io_a_q;
  assign IO_B     = io_b_q;
  assign GAIN_UPD = gain_upd_q;

endmodule

// File: tb/tb_pc104_pid_gain_regs.sv
// Directed self-checking bench for pc104_pid_gain_regs with a queue-based scoreboard of
// expected active gains and GAIN_UPD pulse counts per bus write.
`timescale 1ns/1ps
module tb_pc104_pid_gain_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  SA;
  logic        AEN;
  logic        IOW_N;
  logic        IOR_N;
  logic [15:8] OUT_SD;
  logic [15:8] IN_SD;
  logic        IN_SD_OE;
  logic [7:0]  IO_A;
  logic [7:0]  IO_B;
  logic        GAIN_UPD;

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         pulses;
  } exp_t;
  exp_t sb[$];

  pc104_pid_gain_regs #(
    .BASE_ADDR(10'h300),
    .VERSION  (4'h1),
    .P_RESET  (8'h12),
    .I_RESET  (8'h34)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SA      (SA),
    .AEN     (AEN),
    .IOW_N   (IOW_N),
    .IOR_N   (IOR_N),
    .OUT_SD  (OUT_SD),
    .IN_SD   (IN_SD),
    .IN_SD_OE(IN_SD_OE),
    .IO_A    (IO_A),
    .IO_B    (IO_B),
    .GAIN_UPD(GAIN_UPD)
  );

  always #500 clk = ~clk;

  always @(negedge clk) if (GAIN_UPD) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic rd(input string tag, input logic [9:0] addr, input logic aen,
                    input logic [7:0] exp_d, input logic exp_oe);
    SA    = addr;
    AEN   = aen;
    IOR_N = 1'b0;
    #1;
    chk({tag, "_oe"}, {31'd0, IN_SD_OE}, {31'd0, exp_oe});
    chk({tag, "_d"}, {24'd0, IN_SD}, {24'd0, exp_d});
    IOR_N = 1'b1;
    AEN   = 1'b0;
  endtask

  // Push expectation when the strobe is driven; pop and compare once the write has settled.
  task automatic wr(input string tag, input logic [9:0] addr, input logic [7:0] data,
                    input logic aen, input int low_cycles,
                    input logic [7:0] exp_a, input logic [7:0] exp_b, input int exp_p);
    exp_t e;
    int   base;
    sb.push_back('{a: exp_a, b: exp_b, pulses: exp_p});
    @(negedge clk);
    base   = upd_cnt;
    SA     = addr;
    AEN    = aen;
    OUT_SD = data;
    IOW_N  = 1'b0;
    repeat (low_cycles) @(negedge clk);
    IOW_N = 1'b1;
    repeat (4) @(negedge clk);
    AEN = 1'b0;
    e = sb.pop_front();
    chk({tag, "_io_a"}, {24'd0, IO_A}, {24'd0, e.a});
    chk({tag, "_io_b"}, {24'd0, IO_B}, {24'd0, e.b});
    chk({tag, "_pulses"}, upd_cnt - base, e.pulses);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst    = 1'b1;
    SA     = 10'h300;
    AEN    = 1'b0;
    IOW_N  = 1'b1;
    IOR_N  = 1'b1;
    OUT_SD = 8'h00;

    // Reset values
    @(negedge clk);
    do_reset(2);
    chk("rst_io_a", {24'd0, IO_A}, 32'h12);
    chk("rst_io_b", {24'd0, IO_B}, 32'h34);
    chk("rst_upd", {31'd0, GAIN_UPD}, 32'd0);
    rd("rst_status", 10'h303, 1'b0, 8'h10, 1'b1);

    // Shadow writes leave active gains untouched
    wr("wr_p", 10'h300, 8'hA5, 1'b0, 4, 8'h12, 8'h34, 0);
    wr("wr_i", 10'h301, 8'h3C, 1'b0, 4, 8'h12, 8'h34, 0);
    rd("rd_p", 10'h300, 1'b0, 8'hA5, 1'b1);
    rd("rd_i", 10'h301, 1'b0, 8'h3C, 1'b1);

    // COMMIT with exact edge k+2 latency
    @(negedge clk);
    base   = upd_cnt;
    SA     = 10'h302;
    OUT_SD = 8'h01;
    IOW_N  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("commit_k1_io_a", {24'd0, IO_A}, 32'h12);
    chk("commit_k1_upd", {31'd0, GAIN_UPD}, 32'd0);
    @(negedge clk);
    chk("commit_k2_io_a", {24'd0, IO_A}, 32'hA5);
    chk("commit_k2_io_b", {24'd0, IO_B}, 32'h3C);
    chk("commit_k2_upd", {31'd0, GAIN_UPD}, 32'd1);
    @(negedge clk);
    chk("commit_k3_upd", {31'd0, GAIN_UPD}, 32'd0);
    IOW_N = 1'b1;
    repeat (4) @(negedge clk);
    chk("commit_pulses", upd_cnt - base, 32'd1);
    rd("commit_status", 10'h303, 1'b0, 8'h11, 1'b1);

    // CLEAR beats COMMIT, shadows kept
    wr("clear", 10'h302, 8'h81, 1'b0, 4, 8'h00, 8'h00, 1);
    rd("clear_rd_p", 10'h300, 1'b0, 8'hA5, 1'b1);
    rd("clear_rd_i", 10'h301, 1'b0, 8'h3C, 1'b1);
    rd("clear_status", 10'h303, 1'b0, 8'h12, 1'b1);

    // Qualification: AEN, address miss, long strobe
    wr("aen", 10'h302, 8'h01, 1'b1, 4, 8'h00, 8'h00, 0);
    wr("miss", 10'h310, 8'h01, 1'b0, 4, 8'h00, 8'h00, 0);
    wr("long", 10'h302, 8'h01, 1'b0, 10, 8'hA5, 8'h3C, 1);
    rd("long_status", 10'h303, 1'b0, 8'h13, 1'b1);

    // Read path gating
    rd("rd_ctrl", 10'h302, 1'b0, 8'h00, 1'b1);
    rd("rd_aen", 10'h300, 1'b1, 8'h00, 1'b0);
    rd("rd_miss", 10'h310, 1'b0, 8'h00, 1'b0);
    SA = 10'h300;
    #1;
    chk("idle_oe", {31'd0, IN_SD_OE}, 32'd0);
    chk("idle_d", {24'd0, IN_SD}, 32'd0);
    wr("wr_status", 10'h303, 8'hFF, 1'b0, 4, 8'hA5, 8'h3C, 0);
    rd("wr_status_rd", 10'h303, 1'b0, 8'h13, 1'b1);

    // Counter wrap: 16 commits from reset
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      wr("wrap_commit", 10'h302, 8'h01, 1'b0, 4, 8'h12, 8'h34, 1);
    end
    rd("wrap_status", 10'h303, 1'b0, 8'h10, 1'b1);

    // Reset at edge k+1 of a COMMIT; still-low strobe yields one later write
    wr("pre_p", 10'h300, 8'h77, 1'b0, 4, 8'h12, 8'h34, 0);
    @(negedge clk);
    base   = upd_cnt;
    SA     = 10'h302;
    OUT_SD = 8'h01;
    IOW_N  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_io_a", {24'd0, IO_A}, 32'h12);
    chk("midrst_upd", {31'd0, GAIN_UPD}, 32'd0);
    rd("midrst_rd_p", 10'h300, 1'b0, 8'h12, 1'b1);
    rd("midrst_status", 10'h303, 1'b0, 8'h10, 1'b1);
    SA = 10'h302;
    begin : wait_upd
      int waited = 0;
      while (!GAIN_UPD && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      chk("midrst_upd_seen", {31'd0, GAIN_UPD}, 32'd1);
    end
    repeat (3) @(negedge clk);
    IOW_N = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_pulses", upd_cnt - base, 32'd1);
    chk("midrst_io_b", {24'd0, IO_B}, 32'h34);
    rd("midrst_status2", 10'h303, 1'b0, 8'h11, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
